ram_arbiter: RTL and testbench

//  Shares the single-port word RAM between the CPU instruction-fetch port (read-only)
//  and the load/store data port (read/write). Per port: valid/ready request handshake
//  and a one-cycle-later response strobe. Drives the RAM's addr/in/wen directly.

---
 rtl/ram_arbiter_pkg.sv | 15 +
 rtl/ram_arbiter_if.sv | 30 +++
 rtl/ram_arbiter_starve.sv | 19 +
 rtl/ram_arbiter.sv | 51 +++++
 tb/tb_ram_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared defaults, response tag type and alignment helper
package ram_arbiter_pkg;
   localparam int DEF_ADDR_WIDTH   = 10;
   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_STARVE_LIMIT = 4;
   typedef struct packed {
      logic rsp_if;
      logic rsp_d;
      logic rsp_we;
      logic err;
   } rsp_tag_t;
   function automatic logic is_misaligned(input logic [1:0] lsb);
      return |lsb;
   endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: fetch and load/store request/response channels of the RAM arbiter
interface ram_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  if_req_valid;
   logic [ADDR_WIDTH-1:0] if_req_addr;
   logic                  if_req_ready;
   logic                  if_rsp_valid;
   logic [DATA_WIDTH-1:0] if_rsp_data;
   logic                  if_rsp_err;
   logic                  d_req_valid;
   logic                  d_req_we;
   logic [ADDR_WIDTH-1:0] d_req_addr;
   logic [DATA_WIDTH-1:0] d_req_wdata;
   logic                  d_req_ready;
   logic                  d_rsp_valid;
   logic [DATA_WIDTH-1:0] d_rsp_data;
   logic                  d_rsp_err;
   modport master (
      output if_req_valid, if_req_addr, d_req_valid, d_req_we, d_req_addr, d_req_wdata,
      input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
   );
   modport slave (
      input  if_req_valid, if_req_addr, d_req_valid, d_req_we, d_req_addr, d_req_wdata,
      output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
   );
endinterface

// File: rtl/ram_arbiter_starve.sv
// ram_arbiter_starve: counts stalled fetch cycles and forces a fetch grant at the limit
module ram_arbiter_starve #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_if_valid,
   input  logic i_if_gnt,
   output logic o_force
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] r_cnt;
   assign o_force = (r_cnt == CW'(STARVE_LIMIT));
   // Saturating count of consecutive cycles fetch wanted the RAM but lost it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else if (!i_if_valid || i_if_gnt) r_cnt <= '0;
      else if (!o_force) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port word RAM between instruction fetch and load/store
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ram_arbiter_if.slave          bus,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [DATA_WIDTH-1:0] o_ram_in,
   output logic                  o_ram_wen,
   input  logic [DATA_WIDTH-1:0] i_ram_out
);
   logic     w_force, w_gnt_if, w_gnt_d, w_mis_if, w_mis_d;
   rsp_tag_t r_tag;

   ram_arbiter_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_if_valid (bus.if_req_valid),
      .i_if_gnt   (w_gnt_if),
      .o_force    (w_force)
   );

   assign w_gnt_if = bus.if_req_valid & (~bus.d_req_valid | w_force);
   assign w_gnt_d  = bus.d_req_valid & ~w_gnt_if;
   assign w_mis_if = is_misaligned(bus.if_req_addr[1:0]);
   assign w_mis_d  = is_misaligned(bus.d_req_addr[1:0]);

   assign bus.if_req_ready = w_gnt_if;
   assign bus.d_req_ready  = w_gnt_d;
   assign o_ram_addr = w_gnt_if ? bus.if_req_addr : w_gnt_d ? bus.d_req_addr : '0;
   assign o_ram_in   = bus.d_req_wdata;
   assign o_ram_wen  = w_gnt_d & bus.d_req_we & ~w_mis_d;

   // Remember who owns next cycle's RAM read data and how to qualify it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_tag <= '0;
      else r_tag <= '{rsp_if: w_gnt_if, rsp_d: w_gnt_d, rsp_we: bus.d_req_we,
                      err: (w_gnt_if & w_mis_if) | (w_gnt_d & w_mis_d)};

   assign bus.if_rsp_valid = r_tag.rsp_if;
   assign bus.if_rsp_data  = i_ram_out;
   assign bus.if_rsp_err   = r_tag.rsp_if & r_tag.err;
   assign bus.d_rsp_valid  = r_tag.rsp_d;
   assign bus.d_rsp_data   = (r_tag.rsp_we | r_tag.err) ? '0 : i_ram_out;
   assign bus.d_rsp_err    = r_tag.rsp_d & r_tag.err;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a reference model
module tb_ram_arbiter;
   localparam int AW  = 10;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_in;
   logic          ram_wen;
   logic [DW-1:0] ram_out;
   logic          preload;
   logic [DW-1:0] pre_mem [256];
   logic [DW-1:0] ram_mem [256];
   logic [DW-1:0] ref_mem [256];
   int            starve;
   int            n_chk = 0;
   int            n_err = 0;

   ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .o_ram_addr (ram_addr),
      .o_ram_in   (ram_in),
      .o_ram_wen  (ram_wen),
      .i_ram_out  (ram_out)
   );

   always #5 clk = ~clk;

   // Single-port word RAM with registered read
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= pre_mem[i];
      end else begin
         if (ram_wen) ram_mem[ram_addr[AW-1:2]] <= ram_in;
         ram_out <= ram_mem[ram_addr[AW-1:2]];
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ifv, input logic [AW-1:0] ia, input logic dv,
                        input logic we, input logic [AW-1:0] da, input logic [DW-1:0] wd);
      bus.if_req_valid = ifv;
      bus.if_req_addr  = ia;
      bus.d_req_valid  = dv;
      bus.d_req_we     = we;
      bus.d_req_addr   = da;
      bus.d_req_wdata  = wd;
   endtask

   // One clock of traffic: check grant/RAM drive before the edge, responses after it
   task automatic cycle(input logic ifv, input logic [AW-1:0] ia, input logic dv,
                        input logic we, input logic [AW-1:0] da, input logic [DW-1:0] wd);
      logic          gi, gd, mi, md;
      logic [DW-1:0] rd;
      drive(ifv, ia, dv, we, da, wd);
      gi = ifv && (!dv || starve == LIM);
      gd = dv && !gi;
      mi = ia[1:0] != 2'b00;
      md = da[1:0] != 2'b00;
      #1;
      chk("if_req_ready", bus.if_req_ready, gi);
      chk("d_req_ready", bus.d_req_ready, gd);
      chk("one_grant", bus.if_req_ready & bus.d_req_ready, 0);
      chk("ram_wen", ram_wen, gd && we && !md);
      chk("ram_addr", ram_addr, gi ? ia : gd ? da : '0);
      @(posedge clk);
      rd = gi ? ref_mem[ia[AW-1:2]] : ref_mem[da[AW-1:2]];
      if (gd && we && !md) ref_mem[da[AW-1:2]] = wd;
      starve = (ifv && !gi) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
      #1;
      chk("if_rsp_valid", bus.if_rsp_valid, gi);
      chk("if_rsp_err", bus.if_rsp_err, gi && mi);
      if (gi) chk("if_rsp_data", bus.if_rsp_data, rd);
      chk("d_rsp_valid", bus.d_rsp_valid, gd);
      chk("d_rsp_err", bus.d_rsp_err, gd && md);
      if (gd) chk("d_rsp_data", bus.d_rsp_data, (we || md) ? '0 : rd);
      @(negedge clk);
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   initial begin
      rst_n   = 1'b0;
      preload = 1'b1;
      starve  = 0;
      drive(0, '0, 0, 0, '0, '0);
      for (int i = 0; i < 256; i++) begin
         pre_mem[i] = $urandom;
         ref_mem[i] = pre_mem[i];
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      preload = 1'b0;
      chk("rst_if_rsp_valid", bus.if_rsp_valid, 0);
      chk("rst_d_rsp_valid", bus.d_rsp_valid, 0);
      chk("rst_if_rsp_err", bus.if_rsp_err, 0);
      chk("rst_d_rsp_err", bus.d_rsp_err, 0);
      chk("rst_ram_wen", ram_wen, 0);
      chk("rst_ram_addr", ram_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // Fetch-only stream, back to back
      cycle(1, 10'h004, 0, 0, '0, '0);
      cycle(1, 10'h008, 0, 0, '0, '0);
      cycle(1, 10'h00C, 0, 0, '0, '0);
      // Store then load of the same word
      cycle(0, '0, 1, 1, 10'h010, 32'hDEADBEEF);
      cycle(0, '0, 1, 0, 10'h010, '0);
      chk("load_after_store", bus.d_rsp_data, 32'hDEADBEEF);
      // Idle
      repeat (10) cycle(0, '0, 0, 0, '0, '0);
      // Contention: data wins LIM cycles, then fetch
      for (int i = 0; i < 3 * (LIM + 1); i++) begin
         cycle(1, 10'h020, 1, 0, 10'h040, '0);
         chk("contention_pattern", {31'd0, bus.if_rsp_valid}, (i % (LIM + 1) == LIM) ? 1 : 0);
      end
      // Misaligned store must not touch the RAM
      cycle(0, '0, 1, 1, 10'h013, 32'h12345678);
      cycle(0, '0, 1, 0, 10'h010, '0);
      chk("word4_intact", bus.d_rsp_data, 32'hDEADBEEF);
      // Reset right after a fetch accept
      drive(1, 10'h030, 0, 0, '0, '0);
      @(posedge clk);
      #1;
      chk("pre_rst_if_rsp_valid", bus.if_rsp_valid, 1);
      drive(0, '0, 0, 0, '0, '0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_if_rsp_valid", bus.if_rsp_valid, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      starve = 0;
      cycle(0, '0, 0, 0, '0, '0);
      for (int i = 0; i < LIM + 1; i++) cycle(1, 10'h004, 1, 0, 10'h010, '0);
      chk("ram_after_rst", bus.if_rsp_data, ref_mem[1]);
      // Random traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, rnd_addr(), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, rnd_addr(), $urandom);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
